// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//
// Purpose:
//   Shared definitions for the single-clock FIFO (sync_fifo_param) and its
//   storage array (sync_fifo_ram).
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_WIDTH  default geometry used by sync_fifo_param
//   PTR_CALC_W                     width at which the pointer helpers operate
//   ptr_status_t                   full/empty pair derived from two pointers
//   ptr_compare()                  full/empty from write and read pointers
//   ptr_count()                    occupancy from write and read pointers
//
// The helpers take pointers zero-extended to PTR_CALC_W bits together with the
// index width, so one definition serves every FIFO depth. A pointer is
// ADDRESS_WIDTH index bits plus one wrap bit above them.
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // Pointers are widened to this many bits before entering the helpers.
    localparam int PTR_CALC_W = 32;

    typedef struct packed {
        logic full;
        logic empty;
    } ptr_status_t;

    // Mask covering the index bits plus the wrap bit of a pointer.
    function automatic logic [PTR_CALC_W-1:0] ptr_mask(input int addr_w);
        return (PTR_CALC_W'(1) << (addr_w + 1)) - PTR_CALC_W'(1);
    endfunction

    // Empty: both pointers identical (index and wrap bit).
    // Full:  index bits identical, wrap bits different, i.e. the XOR of the
    //        two pointers is exactly the wrap bit.
    function automatic ptr_status_t ptr_compare(
        input logic [PTR_CALC_W-1:0] wr_ptr,
        input logic [PTR_CALC_W-1:0] rd_ptr,
        input int                    addr_w
    );
        ptr_status_t               status;
        logic [PTR_CALC_W-1:0]     diff;
        diff         = (wr_ptr ^ rd_ptr) & ptr_mask(addr_w);
        status.empty = (diff == '0);
        status.full  = (diff == (PTR_CALC_W'(1) << addr_w));
        return status;
    endfunction

    // Occupancy is the modular distance from read to write pointer. With the
    // extra wrap bit this spans 0..DEPTH without ambiguity.
    function automatic logic [PTR_CALC_W-1:0] ptr_count(
        input logic [PTR_CALC_W-1:0] wr_ptr,
        input logic [PTR_CALC_W-1:0] rd_ptr,
        input int                    addr_w
    );
        return (wr_ptr - rd_ptr) & ptr_mask(addr_w);
    endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
//
// Purpose:
//   DEPTH x WIDTH storage for sync_fifo_param. One synchronous write port and
//   one read port.
//
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : read port is registered (1-cycle latency). The output register
//               updates only on rd_en and is cleared by srst, so it holds the
//               last word read between reads.
//   defined   : read port is asynchronous; rd_data always shows mem[rd_addr]
//               so the FIFO head is visible without a read request.
//
// Ports:
//   clk      in   clock, all state on posedge
//   srst     in   synchronous active-high reset (read register only; the
//                 array itself is never cleared)
//   wr_en    in   write strobe
//   wr_addr  in   ADDRESS_WIDTH write index
//   wr_data  in   WIDTH write word
//   rd_en    in   read strobe (registered-read build)
//   rd_addr  in   ADDRESS_WIDTH read index
//   rd_data  out  WIDTH read word
// -----------------------------------------------------------------------------
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port. No reset: contents survive a FIFO reset and are simply
    // unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN

    // Asynchronous read so the head word falls through to the output.
    assign rd_data = mem[rd_addr];

    // Strobe and reset are not needed by a combinational read port.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = &{1'b0, rd_en, srst};

`else

    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

`endif

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//
// Purpose:
//   Parameterised single-clock FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds, per-event overflow / underflow
//   pulses and a sticky error flag with clear. No clock-domain crossing.
//
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : registered read, rdata_o/rd_valid_o one cycle after an
//               accepted read; rdata_o holds its value between reads.
//   defined   : first-word-fall-through. rdata_o shows the head whenever the
//               FIFO is non-empty, rd_en_i acknowledges (pops) it and
//               rd_valid_o = !empty_o.
//   Flags, count and error behaviour are the same in both builds.
//
// Parameters:
//   DEPTH          entries, power of two, >= 4
//   WIDTH          data width
//   ADDRESS_WIDTH  index width, $clog2(DEPTH)
//   AF_LEVEL       almost_full_o  when count_o >= AF_LEVEL
//   AE_LEVEL       almost_empty_o when count_o <= AE_LEVEL
//
// Ports:
//   clk_i           in   clock
//   rst_i           in   synchronous active-high reset, overrides everything
//   wr_en_i         in   write request
//   wdata_i         in   write data
//   rd_en_i         in   read request / acknowledge
//   err_clr_i       in   clears error_o (a new error in the same cycle wins)
//   rdata_o         out  read data
//   rd_valid_o      out  rdata_o carries a newly read word
//   full_o          out  DEPTH words stored
//   empty_o         out  no words stored
//   almost_full_o   out  count_o >= AF_LEVEL
//   almost_empty_o  out  count_o <= AE_LEVEL
//   count_o         out  occupancy 0..DEPTH
//   wr_err_o        out  one-cycle pulse, write rejected (FIFO was full)
//   rd_err_o        out  one-cycle pulse, read rejected (FIFO was empty)
//   error_o         out  sticky OR of wr_err_o / rd_err_o
// -----------------------------------------------------------------------------
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL      = DEPTH - 2,
    parameter int AE_LEVEL      = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     rd_en_i,
    input  logic                     err_clr_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     rd_valid_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     almost_full_o,
    output logic                     almost_empty_o,
    output logic [ADDRESS_WIDTH:0]   count_o,
    output logic                     wr_err_o,
    output logic                     rd_err_o,
    output logic                     error_o
);

    localparam int PW = ADDRESS_WIDTH + 1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end

    if (ADDRESS_WIDTH != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("sync_fifo_param: ADDRESS_WIDTH must equal $clog2(DEPTH)");
    end

    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sync_fifo_param: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]          wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]          rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]          count_reg,  count_next;
    logic                   full_reg,   full_next;
    logic                   empty_reg,  empty_next;
    logic                   af_reg,     af_next;
    logic                   ae_reg,     ae_next;
    logic                   wr_err_reg, wr_err_next;
    logic                   rd_err_reg, rd_err_next;
    logic                   error_reg,  error_next;

    logic                   wr_accept;
    logic                   rd_accept;
    ptr_status_t            status_next;
    logic [PTR_CALC_W-1:0]  count_wide;
    logic [WIDTH-1:0]       ram_rd_data;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Acceptance uses the registered flags, so a read in the same cycle
        // never frees room for a write that arrived while full.
        wr_accept   = wr_en_i & ~full_reg;
        rd_accept   = rd_en_i & ~empty_reg;

        wr_ptr_next = wr_ptr_reg + PW'(wr_accept);
        rd_ptr_next = rd_ptr_reg + PW'(rd_accept);

        // Flags and count are computed from the post-edge pointers and then
        // registered, so every status output is a flop.
        status_next = ptr_compare(PTR_CALC_W'(wr_ptr_next),
                                  PTR_CALC_W'(rd_ptr_next), ADDRESS_WIDTH);
        count_wide  = ptr_count(PTR_CALC_W'(wr_ptr_next),
                                PTR_CALC_W'(rd_ptr_next), ADDRESS_WIDTH);

        count_next  = count_wide[PW-1:0];
        full_next   = status_next.full;
        empty_next  = status_next.empty;
        af_next     = (count_wide >= PTR_CALC_W'(AF_LEVEL));
        ae_next     = (count_wide <= PTR_CALC_W'(AE_LEVEL));

        wr_err_next = wr_en_i & full_reg;
        rd_err_next = rd_en_i & empty_reg;

        // A new error outranks a clear arriving in the same cycle.
        if (wr_err_next | rd_err_next) begin
            error_next = 1'b1;
        end else if (err_clr_i) begin
            error_next = 1'b0;
        end else begin
            error_next = error_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            af_reg     <= 1'b0;
            ae_reg     <= 1'b1;
            wr_err_reg <= 1'b0;
            rd_err_reg <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            af_reg     <= af_next;
            ae_reg     <= ae_next;
            wr_err_reg <= wr_err_next;
            rd_err_reg <= rd_err_next;
            error_reg  <= error_next;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    sync_fifo_ram #(
        .DEPTH         (DEPTH),
        .WIDTH         (WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk     (clk_i),
        .srst    (rst_i),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg[ADDRESS_WIDTH-1:0]),
        .wr_data (wdata_i),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_reg[ADDRESS_WIDTH-1:0]),
        .rd_data (ram_rd_data)
    );

    // -------------------------------------------------------------------------
    // Read-side outputs
    // -------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN

    // The head entry is at rd_ptr and the RAM reads it combinationally. While
    // empty the array location is stale, so the output is forced to zero,
    // which also gives the all-zero value straight after reset.
    assign rdata_o    = empty_reg ? '0 : ram_rd_data;
    assign rd_valid_o = ~empty_reg;

`else

    logic rd_valid_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_accept;
        end
    end

    // The RAM output register only loads on an accepted read, so rdata_o
    // keeps the last word read between reads.
    assign rdata_o    = ram_rd_data;
    assign rd_valid_o = rd_valid_reg;

`endif

    assign full_o         = full_reg;
    assign empty_o        = empty_reg;
    assign almost_full_o  = af_reg;
    assign almost_empty_o = ae_reg;
    assign count_o        = count_reg;
    assign wr_err_o       = wr_err_reg;
    assign rd_err_o       = rd_err_reg;
    assign error_o        = error_reg;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Self-checking bench for sync_fifo_param at its default geometry
// (DEPTH=16, WIDTH=8, AF_LEVEL=14, AE_LEVEL=2). Accepted writes are pushed to
// a scoreboard queue; the queue is popped and compared when the FIFO presents
// a word. A small occupancy/error model supplies the expected flags. Builds
// with or without SYNC_FIFO_FWFT_EN.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             rd_en_i = 1'b0;
    logic             err_clr_i = 1'b0;
    logic [WIDTH-1:0] rdata_o;
    logic             rd_valid_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             almost_empty_o;
    logic [4:0]       count_o;
    logic             wr_err_o;
    logic             rd_err_o;
    logic             error_o;

    sync_fifo_param dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .wr_en_i        (wr_en_i),
        .wdata_i        (wdata_i),
        .rd_en_i        (rd_en_i),
        .err_clr_i      (err_clr_i),
        .rdata_o        (rdata_o),
        .rd_valid_o     (rd_valid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .wr_err_o       (wr_err_o),
        .rd_err_o       (rd_err_o),
        .error_o        (error_o)
    );

    always #5 clk = ~clk;

    // Model state and scoreboard
    int               pass_cnt = 0;
    int               total_cnt = 0;
    int               m_count = 0;
    bit               m_error = 1'b0;
    bit               e_wr_err = 1'b0;
    bit               e_rd_err = 1'b0;
    bit               e_rd_valid = 1'b0;
    logic [WIDTH-1:0] m_last_rdata = '0;
    logic [WIDTH-1:0] sb[$];

    // Drives one clock cycle of stimulus, advances the model, and returns #1
    // after the edge with all requests released.
    task automatic drive_cycle(input bit wr, input logic [WIDTH-1:0] wd,
                               input bit rd, input bit clr, input bit rs);
        bit m_full, m_empty, wacc, racc;
        m_full  = (m_count == DEPTH);
        m_empty = (m_count == 0);
        if (rs) begin
            m_count      = 0;
            sb.delete();
            e_wr_err     = 1'b0;
            e_rd_err     = 1'b0;
            e_rd_valid   = 1'b0;
            m_error      = 1'b0;
            m_last_rdata = '0;
        end else begin
            wacc       = wr && !m_full;
            racc       = rd && !m_empty;
            e_wr_err   = wr && m_full;
            e_rd_err   = rd && m_empty;
            e_rd_valid = racc;
            if (e_wr_err || e_rd_err) m_error = 1'b1;
            else if (clr)             m_error = 1'b0;
            m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
`ifdef SYNC_FIFO_FWFT_EN
            if (racc) void'(sb.pop_front());
`endif
            if (wacc) sb.push_back(wd);
        end
        rst_i     = rs;
        wr_en_i   = wr;
        wdata_i   = wd;
        rd_en_i   = rd;
        err_clr_i = clr;
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(0, '0, 0, 0, 1);
        drive_cycle(0, '0, 0, 0, 1);
        total_cnt += 10;
        if (count_o !== 5'd0)      $display("FAIL reset_count got=%0d exp=0", count_o);      else pass_cnt++;
        if (empty_o !== 1'b1)      $display("FAIL reset_empty got=%b exp=1", empty_o);       else pass_cnt++;
        if (full_o !== 1'b0)       $display("FAIL reset_full got=%b exp=0", full_o);         else pass_cnt++;
        if (almost_empty_o !== 1'b1) $display("FAIL reset_ae got=%b exp=1", almost_empty_o); else pass_cnt++;
        if (almost_full_o !== 1'b0)  $display("FAIL reset_af got=%b exp=0", almost_full_o);  else pass_cnt++;
        if (rd_valid_o !== 1'b0)   $display("FAIL reset_rd_valid got=%b exp=0", rd_valid_o); else pass_cnt++;
        if (rdata_o !== 8'h00)     $display("FAIL reset_rdata got=%h exp=00", rdata_o);      else pass_cnt++;
        if (wr_err_o !== 1'b0)     $display("FAIL reset_wr_err got=%b exp=0", wr_err_o);     else pass_cnt++;
        if (rd_err_o !== 1'b0)     $display("FAIL reset_rd_err got=%b exp=0", rd_err_o);     else pass_cnt++;
        if (error_o !== 1'b0)      $display("FAIL reset_error got=%b exp=0", error_o);       else pass_cnt++;
        $display("reset: count=%0d empty=%b", count_o, empty_o);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive_cycle(1, WIDTH'(i), 0, 0, 0);
            total_cnt += 5;
            if (count_o !== 5'(m_count)) $display("FAIL fill_count got=%0d exp=%0d", count_o, m_count); else pass_cnt++;
            if (full_o !== (m_count == DEPTH)) $display("FAIL fill_full got=%b exp=%b", full_o, m_count == DEPTH); else pass_cnt++;
            if (empty_o !== (m_count == 0)) $display("FAIL fill_empty got=%b exp=%b", empty_o, m_count == 0); else pass_cnt++;
            if (almost_full_o !== (m_count >= AF)) $display("FAIL fill_af got=%b exp=%b count=%0d", almost_full_o, m_count >= AF, m_count); else pass_cnt++;
            if (almost_empty_o !== (m_count <= AE)) $display("FAIL fill_ae got=%b exp=%b count=%0d", almost_empty_o, m_count <= AE, m_count); else pass_cnt++;
            $display("write %h: count=%0d full=%b af=%b ae=%b", WIDTH'(i), count_o, full_o, almost_full_o, almost_empty_o);
        end
    endtask

    task automatic test_overflow_drain();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, WIDTH'(8'hF0 + i), 0, 0, 0);
            total_cnt += 4;
            if (wr_err_o !== 1'b1)  $display("FAIL ovf_wr_err got=%b exp=1", wr_err_o); else pass_cnt++;
            if (error_o !== 1'b1)   $display("FAIL ovf_error got=%b exp=1", error_o); else pass_cnt++;
            if (count_o !== 5'd16)  $display("FAIL ovf_count got=%0d exp=16", count_o); else pass_cnt++;
            if (full_o !== 1'b1)    $display("FAIL ovf_full got=%b exp=1", full_o); else pass_cnt++;
            $display("overflow write %0d: wr_err=%b count=%0d", i, wr_err_o, count_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            exp = sb[0];
            total_cnt++;
            if (rdata_o !== exp) $display("FAIL drain_data got=%h exp=%h", rdata_o, exp); else pass_cnt++;
            drive_cycle(0, '0, 1, 0, 0);
            total_cnt++;
            if (rd_valid_o !== (m_count != 0)) $display("FAIL drain_valid got=%b exp=%b", rd_valid_o, m_count != 0); else pass_cnt++;
`else
            drive_cycle(0, '0, 1, 0, 0);
            total_cnt++;
            if (rd_valid_o !== e_rd_valid) $display("FAIL drain_valid got=%b exp=%b", rd_valid_o, e_rd_valid); else pass_cnt++;
            if (rd_valid_o === 1'b1 && sb.size() > 0) begin
                exp = sb.pop_front();
                m_last_rdata = exp;
                total_cnt++;
                if (rdata_o !== exp) $display("FAIL drain_data got=%h exp=%h", rdata_o, exp); else pass_cnt++;
            end
`endif
            total_cnt += 2;
            if (count_o !== 5'(m_count)) $display("FAIL drain_count got=%0d exp=%0d", count_o, m_count); else pass_cnt++;
            if (wr_err_o !== 1'b0) $display("FAIL drain_wr_err got=%b exp=0", wr_err_o); else pass_cnt++;
            $display("read %0d: data=%h valid=%b count=%0d", i, rdata_o, rd_valid_o, count_o);
        end
        total_cnt += 2;
        if (empty_o !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty_o); else pass_cnt++;
        if (almost_empty_o !== 1'b1) $display("FAIL drain_ae got=%b exp=1", almost_empty_o); else pass_cnt++;
    endtask

    task automatic test_underflow_err();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, '0, 1, 0, 0);
            total_cnt += 3;
            if (rd_err_o !== 1'b1)   $display("FAIL udf_rd_err got=%b exp=1", rd_err_o); else pass_cnt++;
            if (rd_valid_o !== 1'b0) $display("FAIL udf_rd_valid got=%b exp=0", rd_valid_o); else pass_cnt++;
            if (count_o !== 5'd0)    $display("FAIL udf_count got=%0d exp=0", count_o); else pass_cnt++;
`ifndef SYNC_FIFO_FWFT_EN
            total_cnt++;
            if (rdata_o !== m_last_rdata) $display("FAIL udf_rdata got=%h exp=%h", rdata_o, m_last_rdata); else pass_cnt++;
`endif
            $display("underflow read %0d: rd_err=%b rdata=%h", i, rd_err_o, rdata_o);
        end
        drive_cycle(0, '0, 0, 1, 0);
        total_cnt += 2;
        if (error_o !== m_error) $display("FAIL clr_error got=%b exp=%b", error_o, m_error); else pass_cnt++;
        if (rd_err_o !== 1'b0)   $display("FAIL clr_rd_err got=%b exp=0", rd_err_o); else pass_cnt++;
        $display("err_clr: error=%b", error_o);
        drive_cycle(0, '0, 1, 1, 0);
        total_cnt += 2;
        if (error_o !== m_error) $display("FAIL clr_vs_set got=%b exp=%b", error_o, m_error); else pass_cnt++;
        if (rd_err_o !== 1'b1)   $display("FAIL clr_vs_set_rd_err got=%b exp=1", rd_err_o); else pass_cnt++;
        $display("err_clr with new error: error=%b", error_o);
        drive_cycle(0, '0, 0, 1, 0);
        total_cnt++;
        if (error_o !== 1'b0) $display("FAIL clr_final got=%b exp=0", error_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 8; i++) drive_cycle(1, WIDTH'(8'h20 + i), 0, 0, 0);
        total_cnt++;
        if (count_o !== 5'd8) $display("FAIL b2b_fill_count got=%0d exp=8", count_o); else pass_cnt++;
        for (int i = 0; i < 58; i++) begin
            // 50 simultaneous read/write cycles, then 8 plain reads to drain.
            bit wr;
            wr = (i < 50);
`ifdef SYNC_FIFO_FWFT_EN
            if (m_count != 0) begin
                exp = sb[0];
                total_cnt++;
                if (rdata_o !== exp) $display("FAIL b2b_data got=%h exp=%h", rdata_o, exp); else pass_cnt++;
            end
            drive_cycle(wr, WIDTH'(8'h40 + i), 1, 0, 0);
`else
            drive_cycle(wr, WIDTH'(8'h40 + i), 1, 0, 0);
            total_cnt++;
            if (rd_valid_o !== e_rd_valid) $display("FAIL b2b_valid got=%b exp=%b", rd_valid_o, e_rd_valid); else pass_cnt++;
            if (rd_valid_o === 1'b1 && sb.size() > 0) begin
                exp = sb.pop_front();
                m_last_rdata = exp;
                total_cnt++;
                if (rdata_o !== exp) $display("FAIL b2b_data got=%h exp=%h", rdata_o, exp); else pass_cnt++;
            end
`endif
            total_cnt++;
            if (count_o !== 5'(m_count)) $display("FAIL b2b_count got=%0d exp=%0d", count_o, m_count); else pass_cnt++;
            $display("b2b %0d: wr=%b data=%h count=%0d", i, wr, rdata_o, count_o);
        end
        total_cnt++;
        if (empty_o !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", empty_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive_cycle(0, '0, 1, 0, 0);
        total_cnt++;
        if (error_o !== 1'b1) $display("FAIL mid_pre_error got=%b exp=1", error_o); else pass_cnt++;
        for (int i = 0; i < 5; i++) drive_cycle(1, WIDTH'(8'h50 + i), 0, 0, 0);
        total_cnt++;
        if (count_o !== 5'd5) $display("FAIL mid_fill_count got=%0d exp=5", count_o); else pass_cnt++;
        // Reset with both requests asserted: reset must win.
        drive_cycle(1, 8'hEE, 1, 0, 1);
        total_cnt += 6;
        if (count_o !== 5'd0)        $display("FAIL mid_count got=%0d exp=0", count_o); else pass_cnt++;
        if (empty_o !== 1'b1)        $display("FAIL mid_empty got=%b exp=1", empty_o); else pass_cnt++;
        if (almost_empty_o !== 1'b1) $display("FAIL mid_ae got=%b exp=1", almost_empty_o); else pass_cnt++;
        if (error_o !== 1'b0)        $display("FAIL mid_error got=%b exp=0", error_o); else pass_cnt++;
        if (full_o !== 1'b0)         $display("FAIL mid_full got=%b exp=0", full_o); else pass_cnt++;
        if (rd_valid_o !== 1'b0)     $display("FAIL mid_rd_valid got=%b exp=0", rd_valid_o); else pass_cnt++;
        $display("mid reset: count=%0d empty=%b error=%b", count_o, empty_o, error_o);
        drive_cycle(1, 8'h77, 0, 0, 0);
        total_cnt += 2;
        if (count_o !== 5'd1) $display("FAIL mid_wr_count got=%0d exp=1", count_o); else pass_cnt++;
        if (empty_o !== 1'b0) $display("FAIL mid_wr_empty got=%b exp=0", empty_o); else pass_cnt++;
`ifdef SYNC_FIFO_FWFT_EN
        total_cnt++;
        if (rdata_o !== sb[0]) $display("FAIL mid_data got=%h exp=%h", rdata_o, sb[0]); else pass_cnt++;
        drive_cycle(0, '0, 1, 0, 0);
`else
        drive_cycle(0, '0, 1, 0, 0);
        total_cnt++;
        if (rd_valid_o !== 1'b1) $display("FAIL mid_rd_valid2 got=%b exp=1", rd_valid_o); else pass_cnt++;
        if (rd_valid_o === 1'b1 && sb.size() > 0) begin
            logic [WIDTH-1:0] exp;
            exp = sb.pop_front();
            m_last_rdata = exp;
            total_cnt++;
            if (rdata_o !== exp) $display("FAIL mid_data got=%h exp=%h", rdata_o, exp); else pass_cnt++;
        end
`endif
        total_cnt++;
        if (empty_o !== 1'b1) $display("FAIL mid_end_empty got=%b exp=1", empty_o); else pass_cnt++;
        $display("post-reset read: data=%h empty=%b", rdata_o, empty_o);
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        drive_cycle(1, 8'hA5, 0, 0, 0);
        total_cnt += 2;
        if (rdata_o !== 8'hA5)   $display("FAIL fwft_data got=%h exp=a5", rdata_o); else pass_cnt++;
        if (rd_valid_o !== 1'b1) $display("FAIL fwft_valid got=%b exp=1", rd_valid_o); else pass_cnt++;
        drive_cycle(0, '0, 1, 0, 0);
        total_cnt += 2;
        if (empty_o !== 1'b1)    $display("FAIL fwft_empty got=%b exp=1", empty_o); else pass_cnt++;
        if (rd_valid_o !== 1'b0) $display("FAIL fwft_valid_after got=%b exp=0", rd_valid_o); else pass_cnt++;
        $display("fwft: head=a5 popped, empty=%b", empty_o);
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_err();
        test_back_to_back();
        test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo_param

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the successor to the team's dual-clock FIFO, for blocks that share one clock domain.
- Adds over that FIFO: occupancy count, programmable almost-full/almost-empty thresholds, per-event overflow/underflow pulses, and a sticky error flag with a clear input.
- Sits between producer and consumer datapaths inside one clock domain. No CDC logic.

Parameters:
DEPTH, 16, number of entries; power of 2, minimum 4
WIDTH, 8, data word width in bits
ADDRESS_WIDTH, $clog2(DEPTH), pointer index width
AF_LEVEL, DEPTH-2, almost_full_o asserts when count_o >= AF_LEVEL
AE_LEVEL, 2, almost_empty_o asserts when count_o <= AE_LEVEL

Ports:
clk_i  in  1  single clock, all logic on posedge
rst_i  in  1  synchronous, active-high reset
wr_en_i  in  1  write request
wdata_i  in  WIDTH  write data
rd_en_i  in  1  read request (acknowledge in FWFT mode)
err_clr_i  in  1  clears sticky error_o
rdata_o  out  WIDTH  read data
rd_valid_o  out  1  rdata_o holds a newly read word
full_o  out  1  FIFO holds DEPTH words
empty_o  out  1  FIFO holds 0 words
almost_full_o  out  1  count_o >= AF_LEVEL
almost_empty_o  out  1  count_o <= AE_LEVEL
count_o  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH
wr_err_o  out  1  one-cycle pulse: write rejected
rd_err_o  out  1  one-cycle pulse: read rejected
error_o  out  1  sticky OR of wr_err_o and rd_err_o

Behaviour:
Clock, reset and pointers
- One clock (clk_i). Reset rst_i is synchronous and active-high.
- Pointers wr_ptr and rd_ptr are ADDRESS_WIDTH+1 bits wide; the MSB is the wrap bit.
- empty when pointers are equal. full when indices are equal and wrap bits differ.
- Pointers wrap naturally from DEPTH-1 to 0 and toggle the wrap bit.

Reset
- rst_i high at a posedge sets: pointers=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, rdata_o=0, rd_valid_o=0, wr_err_o=0, rd_err_o=0, error_o=0.
- Reset wins over every other input. An asserted reset mid-operation discards all contents; memory contents are not cleared.

Write and read acceptance
- Write accepted iff wr_en_i=1 and full_o=0. wdata_i is stored at wr_ptr and wr_ptr increments.
- wr_en_i=1 while full_o=1: no store, wr_err_o=1 next cycle. A read accepted in the same cycle does not rescue the write.
- Read accepted iff rd_en_i=1 and empty_o=0. rd_ptr increments.
- rd_en_i=1 while empty_o=1: rd_err_o=1 next cycle, rdata_o unchanged.

Simultaneous events
- Simultaneous accepted read and write: count_o is unchanged and both pointers advance.

Latency and status outputs
- Default mode read latency: rdata_o and rd_valid_o are registered and appear 1 cycle after the accepted read.
- rdata_o holds its last value otherwise; rd_valid_o is high for exactly that one cycle.
- All flags and count_o are registered and reflect accepted operations 1 cycle after the edge.
- A write to an empty FIFO clears empty_o on the next cycle.

Sticky error
- error_o sets on any wr_err_o/rd_err_o and holds until err_clr_i=1.
- Set has priority over a clear in the same cycle.

Parameter checks
- Elaboration-time check: AE_LEVEL < AF_LEVEL <= DEPTH; otherwise $error.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rdata_o shows the head entry whenever empty_o=0.
  - rd_en_i acts as acknowledge and pops the head; the next entry appears the following cycle.
  - rd_valid_o = !empty_o.
  - Write-to-visible latency is 1 cycle.
  - count_o includes the displayed head word.
- Undefined: registered read with 1-cycle latency, as described under Behaviour.
- Flag, error and count semantics are identical in both modes.

Decomposition:
- Package sync_fifo_pkg holds:
  - pointer-compare function (full/empty from two ADDRESS_WIDTH+1 pointers);
  - count computation function;
  - shared default constants (DEFAULT_DEPTH, DEFAULT_WIDTH).
- One sub-module, sync_fifo_ram: DEPTH x WIDTH array with one synchronous write port and one read port. The read port is registered by default and asynchronous under SYNC_FIFO_FWFT_EN.
- Control, flags and errors stay in the top module.

Test Plan:
- Reset, then write 16 words (0x01..0x10) on consecutive cycles -> full_o=1 and count_o=16 one cycle after the 16th write; almost_full_o=1 from count 14.
- From full, 3 extra writes -> 3 wr_err_o pulses, error_o=1, count_o stays 16; then read 16 -> data 0x01..0x10 in order, rd_valid_o each cycle; empty_o=1 after the last read.
- Read 3 times while empty -> 3 rd_err_o pulses, rdata_o unchanged; err_clr_i=1 for one cycle -> error_o=0; err_clr_i together with a new error -> error_o stays 1.
- Fill to 8, then 50 cycles of simultaneous wr_en_i and rd_en_i -> count_o stays 8 and data order is preserved across pointer wrap.
- Fill to 5, then assert rst_i for one cycle mid-stream -> next cycle count_o=0, empty_o=1, almost_empty_o=1, error_o=0; a subsequent write/read returns the new data.
- With SYNC_FIFO_FWFT_EN: write 0xA5 into empty FIFO -> next cycle rdata_o=0xA5 and rd_valid_o=1 with no rd_en_i; pulse rd_en_i -> empty_o=1 next cycle.
